// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS main control: state encodings,
// instruction field values, ALU operation codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] F_SRA = 6'h03;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_MUL = 6'h18;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    // ALU operation codes, shared with the ALU and ALU-control decoder
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_MUL = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_LUI = 4'd9;
    localparam logic [3:0] ALU_NOR = 4'd12;

    // Mux selects
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_RS    = 2'd1;
    localparam logic [1:0] SRC_A_SHAMT = 2'd2;

    localparam logic [2:0] SRC_B_RT     = 3'd0;
    localparam logic [2:0] SRC_B_FOUR   = 3'd1;
    localparam logic [2:0] SRC_B_IMM    = 3'd2;
    localparam logic [2:0] SRC_B_IMM_SH = 3'd3;
    localparam logic [2:0] SRC_B_ZERO   = 3'd4;

    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

endpackage

// File: rtl/mc_rfunct_dec.sv
// R-type funct decoder: maps funct to ALU operation and ALU source-A select,
// and flags functs the datapath cannot execute. jr is handled by the caller.
module mc_rfunct_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_code,
    output logic [1:0] src_a,
    output logic       legal
);

    // Table lookup; shifts take the shift amount on ALU source A
    always_comb begin
        alu_code = ALU_ADD;
        src_a    = SRC_A_RS;
        legal    = 1'b1;
        case (funct)
            F_ADD: alu_code = ALU_ADD;
            F_SUB: alu_code = ALU_SUB;
            F_AND: alu_code = ALU_AND;
            F_OR:  alu_code = ALU_OR;
            F_SLT: alu_code = ALU_SLT;
            F_NOR: alu_code = ALU_NOR;
            F_MUL: alu_code = ALU_MUL;
            F_SRA: begin
                alu_code = ALU_SRA;
                src_a    = SRC_A_SHAMT;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM. The state register is the only storage;
// all datapath controls are decoded combinationally from the state, the
// instruction fields, mem_ready_i and zero_i, and are forced to 0 in reset.
//
// Memory handshake: mem_read_o / mem_write_o are requests held stable from the
// first cycle of an access until the cycle in which mem_ready_i=1; the access
// completes in exactly that cycle and the FSM advances on the following edge.
module mc_control
    import mc_pkg::*;
#(
    parameter int ALU_W = 4,
    parameter int ST_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic [4:0]       rt_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic [1:0]       alu_src_a_o,
    output logic [2:0]       alu_src_b_o,
    output logic [ALU_W-1:0] alu_ctrl_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             illegal_o,
    output logic [ST_W-1:0]  state_o
);

    state_t     state, next_state;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write, illegal;
    logic [1:0] pc_src, alu_src_a, reg_dst, mem_to_reg;
    logic [2:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [3:0] r_alu;
    logic [1:0] r_src_a;
    logic       r_legal;

    mc_rfunct_dec u_rfunct_dec (
        .funct    (funct_i),
        .alu_code (r_alu),
        .src_a    (r_src_a),
        .legal    (r_legal)
    );

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_FETCH;
        else       state <= next_state;
    end

    // Next-state and per-state datapath controls
    always_comb begin
        next_state = state;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RT;
        alu_ctrl   = ALU_AND;
        reg_write  = 1'b0;
        reg_dst    = REG_DST_RT;
        mem_to_reg = M2R_ALUOUT;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                alu_ctrl  = ALU_ADD;
                if (mem_ready_i) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut
                alu_src_b  = SRC_B_IMM_SH;
                alu_ctrl   = ALU_ADD;
                next_state = S_FETCH;
                case (opcode_i)
                    OP_LW, OP_SW:             next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:           next_state = S_BRANCH;
                    OP_J:                     next_state = S_JUMP;
                    OP_JAL:                   next_state = S_JAL;
                    OP_ADDI, OP_SLTI, OP_LUI: next_state = S_I_EXEC;
                    OP_RTYPE: begin
                        if (funct_i == F_JR) next_state = S_JR;
                        else if (r_legal)    next_state = S_R_EXEC;
                        else                 illegal    = 1'b1;
                    end
                    OP_REGIMM: begin
                        if (rt_i == 5'd0) next_state = S_BRANCH;
                        else              illegal    = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = SRC_A_RS;
                alu_src_b  = SRC_B_IMM;
                alu_ctrl   = ALU_ADD;
                next_state = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready_i) next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                next_state = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready_i) next_state = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a  = r_src_a;
                alu_ctrl   = r_alu;
                next_state = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REG_DST_RD;
                next_state = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_IMM;
                case (opcode_i)
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    OP_LUI:  alu_ctrl = ALU_LUI;
                    default: alu_ctrl = ALU_ADD;
                endcase
                next_state = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                // bltz compares rs<0 via slt against zero; the branch is taken
                // when the slt result is non-zero
                pc_src    = PC_SRC_ALUOUT;
                alu_src_a = SRC_A_RS;
                if (opcode_i == OP_REGIMM) begin
                    alu_src_b = SRC_B_ZERO;
                    alu_ctrl  = ALU_SLT;
                    pc_write  = ~zero_i;
                end else begin
                    alu_src_b = SRC_B_RT;
                    alu_ctrl  = ALU_SUB;
                    pc_write  = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
                end
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JUMP;
                next_state = S_FETCH;
            end
            S_JAL: begin
                // PC already holds the return address from the fetch increment
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = REG_DST_R31;
                mem_to_reg = M2R_PC;
                next_state = S_FETCH;
            end
            S_JR: begin
                pc_write   = 1'b1;
                pc_src     = PC_SRC_RS;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Output gating: reset silences every enable and select immediately
    always_comb begin
        pc_write_o   = pc_write & ~rst_i;
        iord_o       = iord & ~rst_i;
        mem_read_o   = mem_read & ~rst_i;
        mem_write_o  = mem_write & ~rst_i;
        ir_write_o   = ir_write & ~rst_i;
        reg_write_o  = reg_write & ~rst_i;
        illegal_o    = illegal & ~rst_i;
        pc_src_o     = rst_i ? 2'd0 : pc_src;
        alu_src_a_o  = rst_i ? 2'd0 : alu_src_a;
        alu_src_b_o  = rst_i ? 3'd0 : alu_src_b;
        alu_ctrl_o   = rst_i ? '0 : ALU_W'(alu_ctrl);
        reg_dst_o    = rst_i ? 2'd0 : reg_dst;
        mem_to_reg_o = rst_i ? 2'd0 : mem_to_reg;
        state_o      = ST_W'(state);
    end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: directed instruction sequences followed by random
// instructions with random memory wait states, checked cycle by cycle against
// a per-instruction expected-cycle list built from the instruction semantics.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic [4:0] rt;
    logic       zero, mem_ready;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write, illegal;
    logic [1:0] pc_src, alu_src_a, reg_dst, mem_to_reg;
    logic [2:0] alu_src_b;
    logic [3:0] alu_ctrl, state;

    int vectors    = 0;
    int miscompares = 0;

    // One expected cycle: enables always checked, selects checked unless -1
    typedef struct {
        int st;
        bit rdy, z;
        bit pcw, mr, mw, irw, rw, ill;
        int iord, pcs, a, b, alu, dst, m2r;
    } cyc_t;

    cyc_t exp_q[$];

    // R-type table: funct, ALU code, source-A select
    int r_fn[8]  = '{'h20, 'h22, 'h24, 'h25, 'h2A, 'h27, 'h18, 'h03};
    int r_alu[8] = '{2, 6, 0, 1, 7, 12, 3, 8};
    int r_sa[8]  = '{1, 1, 1, 1, 1, 1, 1, 2};

    mc_control #(.ALU_W(4), .ST_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .opcode_i     (opcode),
        .funct_i      (funct),
        .rt_i         (rt),
        .zero_i       (zero),
        .mem_ready_i  (mem_ready),
        .pc_write_o   (pc_write),
        .pc_src_o     (pc_src),
        .iord_o       (iord),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .ir_write_o   (ir_write),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_ctrl_o   (alu_ctrl),
        .reg_write_o  (reg_write),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .illegal_o    (illegal),
        .state_o      (state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        vectors++;
        assert (obs === 32'(expv)) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic cyc_t blank(input int st);
        cyc_t c;
        c.st = st; c.rdy = 1'b1; c.z = 1'b0;
        c.pcw = 0; c.mr = 0; c.mw = 0; c.irw = 0; c.rw = 0; c.ill = 0;
        c.iord = -1; c.pcs = -1; c.a = -1; c.b = -1; c.alu = -1; c.dst = -1; c.m2r = -1;
        return c;
    endfunction

    // Reference model: expected cycles of one instruction
    task automatic model(input int opc, input int fn, input int rtv, input bit z,
                         input int wf, input int wm);
        cyc_t c;
        int   ra, rs;
        bit   legal;
        ra = -1; rs = -1;
        for (int i = 0; i < 8; i++) if (r_fn[i] == fn) begin ra = r_alu[i]; rs = r_sa[i]; end
        c = blank(0); c.mr = 1; c.iord = 0; c.a = 0; c.b = 1; c.alu = 2; c.rdy = 0;
        for (int i = 0; i < wf; i++) exp_q.push_back(c);
        c.rdy = 1; c.irw = 1; c.pcw = 1; c.pcs = 0;
        exp_q.push_back(c);
        legal = (opc == 'h23) || (opc == 'h2B) || (opc == 0 && (fn == 'h08 || ra >= 0)) ||
                (opc == 4) || (opc == 5) || (opc == 1 && rtv == 0) || (opc == 2) ||
                (opc == 3) || (opc == 'h08) || (opc == 'h0A) || (opc == 'h0F);
        c = blank(1); c.a = 0; c.b = 3; c.alu = 2; c.ill = !legal;
        exp_q.push_back(c);
        if (!legal) return;
        case (opc)
            'h23, 'h2B: begin
                c = blank(2); c.a = 1; c.b = 2; c.alu = 2;
                exp_q.push_back(c);
                if (opc == 'h23) begin
                    c = blank(3); c.mr = 1; c.iord = 1; c.rdy = 0;
                    for (int i = 0; i < wm; i++) exp_q.push_back(c);
                    c.rdy = 1; exp_q.push_back(c);
                    c = blank(4); c.rw = 1; c.dst = 0; c.m2r = 1;
                    exp_q.push_back(c);
                end else begin
                    c = blank(5); c.mw = 1; c.iord = 1; c.rdy = 0;
                    for (int i = 0; i < wm; i++) exp_q.push_back(c);
                    c.rdy = 1; exp_q.push_back(c);
                end
            end
            0: begin
                if (fn == 'h08) begin
                    c = blank(13); c.pcw = 1; c.pcs = 3;
                    exp_q.push_back(c);
                end else begin
                    c = blank(6); c.a = rs; c.b = 0; c.alu = ra;
                    exp_q.push_back(c);
                    c = blank(7); c.rw = 1; c.dst = 1; c.m2r = 0;
                    exp_q.push_back(c);
                end
            end
            1, 4, 5: begin
                c = blank(8); c.pcs = 1; c.a = 1; c.z = z;
                if (opc == 1) begin c.b = 4; c.alu = 7; c.pcw = !z; end
                else begin c.b = 0; c.alu = 6; c.pcw = (opc == 4) ? z : !z; end
                exp_q.push_back(c);
            end
            2: begin
                c = blank(9); c.pcw = 1; c.pcs = 2;
                exp_q.push_back(c);
            end
            3: begin
                c = blank(12); c.pcw = 1; c.pcs = 2; c.rw = 1; c.dst = 2; c.m2r = 2;
                exp_q.push_back(c);
            end
            default: begin
                c = blank(10); c.a = 1; c.b = 2;
                c.alu = (opc == 'h0A) ? 7 : (opc == 'h0F) ? 9 : 2;
                exp_q.push_back(c);
                c = blank(11); c.rw = 1; c.dst = 0; c.m2r = 0;
                exp_q.push_back(c);
            end
        endcase
    endtask

    // Driver: applies IR fields at the start of the instruction, then per-cycle
    // mem_ready/zero, and checks every output mid-cycle
    task automatic run_q(input int opc, input int fn, input int rtv);
        cyc_t c;
        bit   first;
        string t;
        first = 1'b1;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            @(negedge clk);
            if (first) begin
                opcode = 6'(opc); funct = 6'(fn); rt = 5'(rtv);
                first = 1'b0;
            end
            mem_ready = c.rdy;
            zero = c.z;
            #1;
            t = $sformatf("op%02h_st%0d", opc, c.st);
            chk({t, "_state"}, 32'(state), c.st);
            chk({t, "_pc_write"}, 32'(pc_write), int'(c.pcw));
            chk({t, "_mem_read"}, 32'(mem_read), int'(c.mr));
            chk({t, "_mem_write"}, 32'(mem_write), int'(c.mw));
            chk({t, "_ir_write"}, 32'(ir_write), int'(c.irw));
            chk({t, "_reg_write"}, 32'(reg_write), int'(c.rw));
            chk({t, "_illegal"}, 32'(illegal), int'(c.ill));
            chk({t, "_rw_mw_excl"}, 32'(reg_write & mem_write), 0);
            if (c.iord >= 0) chk({t, "_iord"}, 32'(iord), c.iord);
            if (c.pcs >= 0)  chk({t, "_pc_src"}, 32'(pc_src), c.pcs);
            if (c.a >= 0)    chk({t, "_src_a"}, 32'(alu_src_a), c.a);
            if (c.b >= 0)    chk({t, "_src_b"}, 32'(alu_src_b), c.b);
            if (c.alu >= 0)  chk({t, "_alu"}, 32'(alu_ctrl), c.alu);
            if (c.dst >= 0)  chk({t, "_reg_dst"}, 32'(reg_dst), c.dst);
            if (c.m2r >= 0)  chk({t, "_mem_to_reg"}, 32'(mem_to_reg), c.m2r);
        end
    endtask

    task automatic do_instr(input int opc, input int fn, input int rtv, input bit z,
                            input int wf, input int wm);
        model(opc, fn, rtv, z, wf, wm);
        run_q(opc, fn, rtv);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_mem_read"}, 32'(mem_read), 0);
        chk({tag, "_mem_write"}, 32'(mem_write), 0);
        chk({tag, "_pc_write"}, 32'(pc_write), 0);
        chk({tag, "_ir_write"}, 32'(ir_write), 0);
        chk({tag, "_reg_write"}, 32'(reg_write), 0);
        chk({tag, "_src_b"}, 32'(alu_src_b), 0);
        chk({tag, "_alu"}, 32'(alu_ctrl), 0);
    endtask

    initial begin
        int opc, fn, rtv, k;
        int legal_ops[10] = '{'h23, 'h2B, 'h04, 'h05, 'h02, 'h03, 'h08, 'h0A, 'h0F, 'h01};
        int bad_ops[4]    = '{'h3F, 'h10, 'h22, 'h07};
        int bad_fn[3]     = '{'h00, 'h21, 'h3F};

        // Reset held for three cycles
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0;
        opcode = 6'h00; funct = 6'h20; rt = 5'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk_reset_outputs("in_reset");
        end
        @(negedge clk);
        rst = 1'b0;

        // add $3,$1,$2 with zero-wait memory
        do_instr('h00, 'h20, 2, 1'b0, 0, 0);
        // lw: two FETCH waits, one MEM_READ wait, eight cycles
        do_instr('h23, 'h00, 3, 1'b0, 2, 1);
        // beq taken and not taken
        do_instr('h04, 'h00, 1, 1'b1, 0, 0);
        do_instr('h04, 'h00, 1, 1'b0, 0, 0);
        // sra and lui
        do_instr('h00, 'h03, 2, 1'b0, 0, 0);
        do_instr('h0F, 'h00, 4, 1'b0, 0, 0);
        // undecodable opcode
        do_instr('h3F, 'h00, 0, 1'b0, 0, 0);

        // sw interrupted by reset while the write is still pending
        model('h2B, 'h00, 5, 1'b0, 0, 3);
        for (int i = 0; i < 3; i++) void'(exp_q.pop_back());
        run_q('h2B, 'h00, 5);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid_sw");
        @(negedge clk); #1;
        chk_reset_outputs("rst_mid_sw_hold");
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Random instruction mix with random wait states
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 9);
            rtv = 0;
            fn = 0;
            if (k < 4) begin
                opc = legal_ops[$urandom_range(0, 9)];
                rtv = (opc == 'h01) ? 0 : $urandom_range(0, 31);
            end else if (k < 7) begin
                opc = 0;
                fn = r_fn[$urandom_range(0, 7)];
            end else if (k == 7) begin
                opc = 0;
                fn = ($urandom_range(0, 1) == 0) ? 'h08 : bad_fn[$urandom_range(0, 2)];
            end else if (k == 8) begin
                opc = 'h01;
                rtv = $urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 31);
            end else begin
                opc = bad_ops[$urandom_range(0, 3)];
            end
            do_instr(opc, fn, rtv, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Last instruction must have returned to FETCH
        @(negedge clk); #1;
        chk("final_state", 32'(state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
